instruction_fetch_stage: RTL

//   Fetch stage of the RV64 pipeline. Holds the PC, drives the byte address into the

---
 rtl/instruction_fetch_stage.sv | 104 ++++++++++
 1 files changed

// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_stage
// Description : RV64 fetch stage. Holds the PC, addresses a combinational
//               instruction memory and captures the returned word plus its
//               PC into the IF/ID register. Handles PC+4, EX redirect
//               (flush), hazard stall and reset.
//               Optional macro FETCH_BOUNDS_CHECK_EN enables an out-of-range
//               fetch check with a sticky fetch_fault flag.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned IMEM_BYTES = 148,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_target,
    output logic [63:0] inst_address,
    input  logic [31:0] instruction_in,
    output logic [63:0] pc,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        fetch_fault
);

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic c_BOUNDS_CHECK_EN = 1'b1;
`else
    localparam logic c_BOUNDS_CHECK_EN = 1'b0;
`endif

    // Highest byte address at which a full 32-bit word still fits in memory.
    localparam logic [63:0] c_IMEM_LAST = 64'(IMEM_BYTES) - 64'd4;

    logic [63:0] r_pc;
    logic [63:0] r_if_id_pc;
    logic [31:0] r_if_id_instr;
    logic        r_if_id_valid;
    logic        r_fetch_fault;

    logic [63:0] w_target;
    logic        w_pc_out_of_range;
    logic        w_target_out_of_range;

    // Targets are word aligned; low two bits are simply discarded.
    assign w_target = {redirect_target[63:2], 2'b00};

    // Range checks collapse to constant 0 when the bounds check is compiled out.
    assign w_pc_out_of_range     = c_BOUNDS_CHECK_EN && (r_pc > c_IMEM_LAST);
    assign w_target_out_of_range = c_BOUNDS_CHECK_EN && (w_target > c_IMEM_LAST);

    // PC and IF/ID register update: reset > redirect > out-of-range > stall > normal.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_if_id_pc    <= 64'h0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
            r_fetch_fault <= 1'b0;
        end else if (redirect) begin
            // Flush the wrong-path word; range of the new target is judged next cycle,
            // but an in-range target already clears a pending fault.
            r_pc          <= w_target;
            r_if_id_pc    <= r_pc;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
            r_fetch_fault <= r_fetch_fault & w_target_out_of_range;
        end else if (w_pc_out_of_range) begin
            // Park on the bad PC and keep feeding bubbles until redirected.
            r_pc          <= r_pc;
            r_if_id_pc    <= r_pc;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
            r_fetch_fault <= 1'b1;
        end else if (stall) begin
            r_pc          <= r_pc;
            r_if_id_pc    <= r_if_id_pc;
            r_if_id_instr <= r_if_id_instr;
            r_if_id_valid <= r_if_id_valid;
            r_fetch_fault <= r_fetch_fault;
        end else begin
            r_pc          <= r_pc + 64'd4;
            r_if_id_pc    <= r_pc;
            r_if_id_instr <= instruction_in;
            r_if_id_valid <= 1'b1;
            r_fetch_fault <= r_fetch_fault;
        end
    end

    // Memory address comes straight from the PC register, never from control inputs.
    assign inst_address = r_pc;
    assign pc           = r_pc;
    assign if_id_pc     = r_if_id_pc;
    assign if_id_instr  = r_if_id_instr;
    assign if_id_valid  = r_if_id_valid;
    assign fetch_fault  = r_fetch_fault;

endmodule
`default_nettype wire
